// File: rtl/riscspm_pkg.sv
// Shared definitions for the RISC_SPM memory-side units: default widths and
// the read-unit state encoding.
package riscspm_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD,
    S_BAD  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that times the memory read latency; flags the last
// cycle of the wait (cnt == 1) and never wraps below 1.
module lat_counter #(
  parameter int LOAD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int W = $clog2(LOAD + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD);
    end else if (dec && (cnt > W'(1))) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/mem_read_unit.sv
// Read-side request/response unit: issues one registered read strobe per
// accepted request and hands the captured word to the consumer over valid/ready.
module mem_read_unit
  import riscspm_pkg::*;
#(
  parameter int ADDR_W = riscspm_pkg::ADDR_W,
  parameter int DATA_W = riscspm_pkg::DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  rd_state_t state_q, state_d;
  logic      start_rd;
  logic      capture;
  logic      cnt_last;
  logic      cnt_dec;

  // The latency count only runs once the strobe cycle is over, so the word is
  // captured RD_LAT edges after the memory has sampled mem_rd.
  assign cnt_dec = (state_q == S_WAIT) && !mem_rd;

  lat_counter #(.LOAD(RD_LAT)) u_lat_counter (
    .clk  (clk),
    .rst  (rst),
    .load (start_rd),
    .dec  (cnt_dec),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    start_rd  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          start_rd = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_last && !mem_rd) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            start_rd = 1'b1;
            state_d  = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
    end else begin
      mem_rd <= start_rd;
      if (start_rd) begin
        mem_addr <= req_addr;
      end
    end
  end

  // Response register: only a capture in WAIT loads it, so data arriving after
  // an aborted read is never seen by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem_data;
    end else if ((state_q == S_HOLD) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = (state_q == S_WAIT) || (state_q == S_HOLD);

endmodule

// File: tb/tb_mem_read_unit.sv
// Directed bench for mem_read_unit with a latency-accurate memory model and a
// scoreboard of expected response words.
module tb_mem_read_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int rd_pulses = 0;
  logic [DATA_W-1:0] sb [$];

  always #5 clk = ~clk;

  mem_read_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Memory returns ~addr, valid only during the single cycle before the edge
  // RD_LAT edges after mem_rd is sampled; junk otherwise.
  logic [DATA_W-1:0] pipe_d [RD_LAT] = '{default: '0};
  logic              pipe_v [RD_LAT] = '{default: 1'b0};

  always @(posedge clk) begin
    pipe_v[0] <= mem_rd;
    pipe_d[0] <= ~mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mem_data = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 8'hEE;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [ADDR_W-1:0] a, input logic r);
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
  endtask

  // Scoreboard: push on accept, pop on response handshake, both seen mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) rd_pulses++;
      if (rsp_valid && rsp_ready) begin
        check_output("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check_output("sb_rsp_data", rsp_data, sb.pop_front());
      end
      if (req_valid && req_ready) sb.push_back(~req_addr);
    end
  end

  initial begin
    int pulses0;

    // Reset
    apply_stimulus(1'b0, 8'h00, 1'b0);
    #17 rst = 1'b0;
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_mem_rd", mem_rd, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_busy", busy, 0);

    // Single read of 8'h33 with consumer stalled
    apply_stimulus(1'b1, 8'h33, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h99, 1'b0);
    check_output("rd1_mem_rd", mem_rd, 1);
    check_output("rd1_mem_addr", mem_addr, 8'h33);
    check_output("rd1_busy", busy, 1);
    check_output("rd1_req_ready", req_ready, 0);
    tick();
    check_output("rd1_mem_rd_drop", mem_rd, 0);
    check_output("rd1_valid_e1", rsp_valid, 0);
    tick();
    check_output("rd1_valid_e2", rsp_valid, 0);
    tick();
    check_output("rd1_valid_e3", rsp_valid, 1);
    check_output("rd1_data", rsp_data, 8'hCC);
    check_output("rd1_addr_hold", mem_addr, 8'h33);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_valid", rsp_valid, 1);
      check_output("bp_data", rsp_data, 8'hCC);
      check_output("bp_req_ready", req_ready, 0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick();
    check_output("bp_release_valid", rsp_valid, 0);
    check_output("bp_release_busy", busy, 0);
    check_output("bp_release_ready", req_ready, 1);

    // Back-to-back: 8'h3C then 8'h0F accepted on the response handshake
    apply_stimulus(1'b1, 8'h3C, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    check_output("b2b_first_valid", rsp_valid, 1);
    check_output("b2b_first_data", rsp_data, 8'hC3);
    apply_stimulus(1'b1, 8'h0F, 1'b1);
    check_output("b2b_hold_ready", req_ready, 1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("b2b_mem_rd", mem_rd, 1);
    check_output("b2b_mem_addr", mem_addr, 8'h0F);
    check_output("b2b_valid_drop", rsp_valid, 0);
    check_output("b2b_busy", busy, 1);
    tick();
    tick();
    tick();
    check_output("b2b_second_valid", rsp_valid, 1);
    check_output("b2b_second_data", rsp_data, 8'hF0);
    tick();
    check_output("b2b_idle", busy, 0);

    // Request toggled during WAIT is ignored
    apply_stimulus(1'b1, 8'h12, 1'b1);
    tick();
    pulses0 = rd_pulses;
    apply_stimulus(1'b1, 8'hAA, 1'b1);
    check_output("wait_req_ready_a", req_ready, 0);
    tick();
    check_output("wait_req_ready_b", req_ready, 0);
    apply_stimulus(1'b0, 8'hAA, 1'b1);
    tick();
    apply_stimulus(1'b1, 8'hAA, 1'b1);
    check_output("wait_req_ready_c", req_ready, 0);
    check_output("wait_no_mem_rd", mem_rd, 0);
    apply_stimulus(1'b0, 8'hAA, 1'b1);
    tick();
    check_output("wait_rsp_valid", rsp_valid, 1);
    check_output("wait_rsp_data", rsp_data, 8'hED);
    check_output("wait_mem_addr", mem_addr, 8'h12);
    check_output("wait_pulses", 32'(rd_pulses - pulses0), 1);
    tick();
    check_output("wait_idle", busy, 0);

    // Reset one cycle after accept
    apply_stimulus(1'b1, 8'h77, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick();
    rst = 1'b1;
    sb.delete();
    #1;
    check_output("mrst_busy", busy, 0);
    check_output("mrst_mem_addr", mem_addr, 0);
    check_output("mrst_mem_rd", mem_rd, 0);
    check_output("mrst_rsp_data", rsp_data, 0);
    tick();
    tick();
    check_output("mrst_rsp_valid", rsp_valid, 0);
    #3 rst = 1'b0;
    apply_stimulus(1'b1, 8'h55, 1'b1);
    check_output("mrst_req_ready", req_ready, 1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("mrst_mem_rd_new", mem_rd, 1);
    check_output("mrst_mem_addr_new", mem_addr, 8'h55);
    check_output("mrst_no_late_capture", rsp_valid, 0);
    tick();
    tick();
    check_output("mrst_valid_early", rsp_valid, 0);
    tick();
    check_output("mrst_valid", rsp_valid, 1);
    check_output("mrst_data", rsp_data, 8'hAA);
    tick();
    check_output("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
